cla_add_scheduler: RTL and testbench

Shares one `CLA32bit` carry look-ahead adder among `N_REQ` requesters. A round-robin arbiter grants one request at a time, and the scheduler sequences each operation through the adder. A 32-bit add takes one adder pass; a 64-bit add takes two passes, with the low-word carry chained into the high word. Each result is returned on a single valid/ready response port, tagged with the requester id.

---
 rtl/cla_sched_pkg.sv | 19 +
 rtl/CLA32bit.sv | 33 +++
 rtl/rr_arbiter.sv | 39 +++
 rtl/cla_add_scheduler.sv | 175 +++++++++++++++++
 tb/tb_cla_add_scheduler.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cla_sched_pkg.sv
// Shared types, widths and overflow helper for the shared-CLA add scheduler.
package cla_sched_pkg;

  localparam int WORD  = 32;
  localparam int DWORD = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    RESP = 2'd3
  } state_e;

  // Signed overflow from operand and result sign bits at the operation width.
  function automatic logic ovf_detect(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/CLA32bit.sv
// 32-bit carry look-ahead adder: 4-bit look-ahead groups, group carries chained.
module CLA32bit (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic        cg;

  always_comb begin
    g  = a_i & b_i;
    p  = a_i ^ b_i;
    c  = '0;
    cg = cin_i;
    for (int k = 0; k < 8; k++) begin
      c[4*k]   = cg;
      c[4*k+1] = g[4*k] | (p[4*k] & cg);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cg);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & cg);
      cg = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
         | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]) | ((&p[4*k+3 -: 4]) & cg);
    end
    sum_o  = p ^ c;
    cout_o = cg;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin winner select starting at ptr; ptr moves past the winner on accept.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] valid_i,
  input  logic             accept_i,
  output logic             any_o,
  output logic [ID_W-1:0]  win_o,
  output logic [N_REQ-1:0] onehot_o
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;

  // Scan from the far end so the smallest offset from ptr wins.
  always_comb begin
    int idx;
    idx   = 0;
    win_o = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      idx = int'(ptr_q) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (valid_i[idx[ID_W-1:0]]) win_o = idx[ID_W-1:0];
    end
  end

  assign any_o    = |valid_i;
  assign onehot_o = any_o ? (N_REQ'(1) << win_o) : '0;
  assign ptr_d    = (win_o == ID_W'(N_REQ - 1)) ? '0 : win_o + ID_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n)        ptr_q <= '0;
    else if (accept_i) ptr_q <= ptr_d;
  end

endmodule

// File: rtl/cla_add_scheduler.sv
// Shares one CLA32bit among N_REQ requesters; wide adds take a second pass.
//   state | meaning
//   IDLE  | grant offered to arbiter winner, operands captured on handshake
//   LOW   | low-word pass, carry kept for the high pass
//   HIGH  | high-word pass (wide only)
//   RESP  | result held until rsp_ready
module cla_add_scheduler
  import cla_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*DWORD-1:0] req_a,
  input  logic [N_REQ*DWORD-1:0] req_b,
  input  logic [N_REQ-1:0]       req_cin,
  input  logic [N_REQ-1:0]       req_wide,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [DWORD-1:0]       rsp_sum,
  output logic                   rsp_cout,
  output logic                   rsp_ovf
);

  state_e state_q, state_d;
  logic [DWORD-1:0] a_q, a_d, b_q, b_d;
  logic cin_q, cin_d, wide_q, wide_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [WORD-1:0] sum_lo_q, sum_lo_d, sum_hi_q, sum_hi_d;
  logic carry_lo_q, carry_lo_d, cout_q, cout_d, ovf_q, ovf_d;

  logic any_valid, accept;
  logic [ID_W-1:0] win;
  logic [N_REQ-1:0] grant_oh;
  logic [DWORD-1:0] sel_a, sel_b;
  logic sel_cin, sel_wide;
  logic [WORD-1:0] add_a, add_b, add_sum;
  logic add_cin, add_cout;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_i  (req_valid),
    .accept_i (accept),
    .any_o    (any_valid),
    .win_o    (win),
    .onehot_o (grant_oh)
  );

  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_cin  = 1'b0;
    sel_wide = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == ID_W'(i)) begin
        sel_a    = req_a[i*DWORD +: DWORD];
        sel_b    = req_b[i*DWORD +: DWORD];
        sel_cin  = req_cin[i];
        sel_wide = req_wide[i];
      end
    end
  end

  // Only the high pass sees the upper word and the chained low carry.
  always_comb begin
    if (state_q == HIGH) begin
      add_a   = a_q[DWORD-1:WORD];
      add_b   = b_q[DWORD-1:WORD];
      add_cin = carry_lo_q;
    end else begin
      add_a   = a_q[WORD-1:0];
      add_b   = b_q[WORD-1:0];
      add_cin = cin_q;
    end
  end

  CLA32bit u_cla (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (add_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    wide_d     = wide_q;
    id_d       = id_q;
    sum_lo_d   = sum_lo_q;
    sum_hi_d   = sum_hi_q;
    carry_lo_d = carry_lo_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          accept   = 1'b1;
          a_d      = sel_a;
          b_d      = sel_b;
          cin_d    = sel_cin;
          wide_d   = sel_wide;
          id_d     = win;
          sum_hi_d = '0;
          state_d  = LOW;
        end
      end
      LOW: begin
        sum_lo_d   = add_sum;
        carry_lo_d = add_cout;
        if (wide_q) begin
          state_d = HIGH;
        end else begin
          cout_d  = add_cout;
          ovf_d   = ovf_detect(a_q[WORD-1], b_q[WORD-1], add_sum[WORD-1]);
          state_d = RESP;
        end
      end
      HIGH: begin
        sum_hi_d = add_sum;
        cout_d   = add_cout;
        ovf_d    = ovf_detect(a_q[DWORD-1], b_q[DWORD-1], add_sum[WORD-1]);
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      wide_q     <= 1'b0;
      id_q       <= '0;
      sum_lo_q   <= '0;
      sum_hi_q   <= '0;
      carry_lo_q <= 1'b0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cin_q      <= cin_d;
      wide_q     <= wide_d;
      id_q       <= id_d;
      sum_lo_q   <= sum_lo_d;
      sum_hi_q   <= sum_hi_d;
      carry_lo_q <= carry_lo_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
    end
  end

  assign req_ready = (state_q == IDLE) ? grant_oh : '0;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_sum   = {sum_hi_q, sum_lo_q};
  assign rsp_cout  = cout_q;
  assign rsp_ovf   = ovf_q;

endmodule

// File: tb/tb_cla_add_scheduler.sv
// Directed + randomized bench for cla_add_scheduler against an arithmetic reference model.
module tb_cla_add_scheduler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid, req_ready, req_cin, req_wide;
  logic [255:0] req_a, req_b;
  logic         rsp_valid, rsp_ready;
  logic [1:0]   rsp_id;
  logic [63:0]  rsp_sum;
  logic         rsp_cout, rsp_ovf;
  logic [63:0]  op_a [4];
  logic [63:0]  op_b [4];

  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < 4; i++) begin
      req_a[i*64 +: 64] = op_a[i];
      req_b[i*64 +: 64] = op_b[i];
    end
  end

  cla_add_scheduler #(.N_REQ(4), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_wide  (req_wide),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Winner = first valid index at or after the model pointer, modulo 4.
  function automatic int pick(input logic [3:0] mask);
    int idx;
    for (int off = 0; off < 4; off++) begin
      idx = (ptr_m + off) % 4;
      if (mask[idx[1:0]]) return idx;
    end
    return 0;
  endfunction

  // Reference: plain wide-integer addition; overflow = signed result not representable.
  task automatic model(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic wide,
                       output logic [63:0] sum, output logic cout, output logic ovf);
    logic [64:0] u;
    logic [65:0] s;
    logic [32:0] un;
    logic [33:0] sn;
    if (wide) begin
      u    = {1'b0, a} + {1'b0, b} + 65'(cin);
      s    = {a[63], a[63], a} + {b[63], b[63], b} + 66'(cin);
      sum  = u[63:0];
      cout = u[64];
      ovf  = !((s[65:63] == 3'b000) || (s[65:63] == 3'b111));
    end else begin
      un   = {1'b0, a[31:0]} + {1'b0, b[31:0]} + 33'(cin);
      sn   = {a[31], a[31], a[31:0]} + {b[31], b[31], b[31:0]} + 34'(cin);
      sum  = {32'h0, un[31:0]};
      cout = un[32];
      ovf  = !((sn[33:31] == 3'b000) || (sn[33:31] == 3'b111));
    end
  endtask

  task automatic set_op(input int i, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic wide);
    op_a[i]     = a;
    op_b[i]     = b;
    req_cin[i]  = cin;
    req_wide[i] = wide;
  endtask

  // Called at a negedge with the DUT in IDLE; returns at the negedge after the response is taken.
  task automatic run_op(input logic [3:0] mask, input int hold, input logic keep, output int dut_w);
    int w;
    logic [63:0] es;
    logic ec, eo, wd;
    req_valid = mask;
    #1;
    w = pick(mask);
    dut_w = -1;
    for (int i = 0; i < 4; i++) if (req_ready[i]) dut_w = i;
    check("grant", 64'(req_ready), 64'(4'b0001 << w));
    wd = req_wide[w];
    model(op_a[w], op_b[w], req_cin[w], wd, es, ec, eo);
    @(posedge clk);
    ptr_m = (w + 1) % 4;
    @(negedge clk);
    if (!keep) req_valid[w] = 1'b0;
    check("low_valid", 64'(rsp_valid), 64'd0);
    check("low_ready", 64'(req_ready), 64'd0);
    if (wd) begin
      @(negedge clk);
      check("high_valid", 64'(rsp_valid), 64'd0);
    end
    @(negedge clk);
    check("rsp_valid", 64'(rsp_valid), 64'd1);
    check("rsp_id", 64'(rsp_id), 64'(w));
    check("rsp_sum", rsp_sum, es);
    check("rsp_cout", 64'(rsp_cout), 64'(ec));
    check("rsp_ovf", 64'(rsp_ovf), 64'(eo));
    check("resp_ready", 64'(req_ready), 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("bp_valid", 64'(rsp_valid), 64'd1);
      check("bp_sum", rsp_sum, es);
      check("bp_id", 64'(rsp_id), 64'(w));
      check("bp_flags", 64'({rsp_cout, rsp_ovf}), 64'({ec, eo}));
      check("bp_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_drop", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    int w;
    int order [6];
    int exp_order [6];
    logic [3:0] mask;

    exp_order = '{0, 1, 2, 3, 0, 1};
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_cin   = '0;
    req_wide  = '0;
    for (int i = 0; i < 4; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_id", 64'(rsp_id), 64'd0);
    check("rst_sum", rsp_sum, 64'd0);
    check("rst_flags", 64'({rsp_cout, rsp_ovf}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // All four requesters held valid from reset.
    for (int i = 0; i < 4; i++)
      set_op(i, {32'h0, $urandom}, {32'h0, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
    for (int k = 0; k < 6; k++) begin
      run_op(4'hF, 0, 1'b1, w);
      order[k] = w;
    end
    for (int k = 0; k < 6; k++) check("fair_order", 64'(order[k]), 64'(exp_order[k]));
    req_valid = '0;

    set_op(0, 64'd10, 64'd5, 1'b0, 1'b0);
    run_op(4'b0001, 0, 1'b0, w);
    set_op(1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1, 1'b0);
    run_op(4'b0010, 0, 1'b0, w);
    set_op(3, 64'h7FFF_FFFF, 64'd1, 1'b0, 1'b0);
    run_op(4'b1000, 0, 1'b0, w);
    set_op(0, 64'hFFFF_FFF6, 64'hFFFF_FFFB, 1'b0, 1'b0);
    run_op(4'b0001, 0, 1'b0, w);
    set_op(2, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
    run_op(4'b0100, 0, 1'b0, w);
    set_op(2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
    run_op(4'b0100, 0, 1'b0, w);
    set_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b1);
    run_op(4'b0010, 0, 1'b0, w);
    set_op(3, 64'h1234_5678_8000_0000, 64'h0000_0001_8000_0000, 1'b1, 1'b1);
    run_op(4'b1000, 0, 1'b0, w);

    // Backpressure with a second requester already waiting.
    set_op(1, 64'hDEAD_BEEF, 64'h1111_1111, 1'b0, 1'b0);
    set_op(2, 64'hCAFE_0000_0000_0001, 64'h0000_F00D_FFFF_FFFF, 1'b1, 1'b1);
    run_op(4'b0110, 5, 1'b1, w);
    mask = 4'b0110;
    mask[w[1:0]] = 1'b0;
    run_op(mask, 3, 1'b0, w);

    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 4; i++)
        set_op(i, {$urandom, $urandom}, {$urandom, $urandom},
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      mask = 4'($urandom_range(1, 15));
      run_op(mask, $urandom_range(0, 2), 1'b0, w);
    end
    req_valid = '0;

    // Reset during the high pass of a wide op.
    set_op(2, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b1);
    req_valid = 4'b0100;
    #1;
    check("mid_grant", 64'(req_ready), 64'(4'b0001 << pick(4'b0100)));
    @(posedge clk);
    ptr_m = 3;
    @(negedge clk);
    req_valid = '0;
    check("mid_low", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    ptr_m = 0;
    check("mid_rst_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_ready", 64'(req_ready), 64'd0);
    check("mid_rst_sum", rsp_sum, 64'd0);
    check("mid_rst_id", 64'(rsp_id), 64'd0);
    check("mid_rst_flags", 64'({rsp_cout, rsp_ovf}), 64'd0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_valid", 64'(rsp_valid), 64'd0);
    end
    for (int i = 0; i < 4; i++)
      set_op(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'($urandom_range(0, 1)));
    run_op(4'hF, 0, 1'b0, w);
    check("post_rst_winner", 64'(w), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
